// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles framed 32-bit words into instruction memory and
// holds the processor in reset until a frame with a good checksum has been loaded.
module imem_boot_loader #(
  parameter int          ADDR_W = 6,
  parameter int          DEPTH  = 64,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [15:0]       word_idx_reg, word_idx_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [7:0]        csum_reg, csum_next;
  logic [31:0]       word_reg, word_next;
  logic              imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]       imem_wdata_reg, imem_wdata_next;
  logic              cpu_reset_reg, cpu_reset_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;

  logic        accept;
  logic [7:0]  csum_acc;
  logic [15:0] hdr_count;
  logic [31:0] word_shifted;

  assign rx_ready     = (state_reg != S_WRITE);
  assign accept       = rx_valid && rx_ready;
  assign csum_acc     = csum_reg ^ rx_byte;
  assign hdr_count    = {cnt_reg[15:8], rx_byte};
  assign word_shifted = {word_reg[23:0], rx_byte};

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign done       = done_reg;
  assign error      = error_reg;

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      csum_reg       <= '0;
      word_reg       <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_reset_reg  <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      word_idx_reg   <= word_idx_next;
      byte_cnt_reg   <= byte_cnt_next;
      csum_reg       <= csum_next;
      word_reg       <= word_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
      cpu_reset_reg  <= cpu_reset_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    word_idx_next   = word_idx_reg;
    byte_cnt_next   = byte_cnt_reg;
    csum_next       = csum_reg;
    word_next       = word_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;
    cpu_reset_next  = cpu_reset_reg;
    done_next       = done_reg;
    error_next      = error_reg;

    case (state_reg)
      // Idle and both terminal states only react to a sync byte (re-arm).
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && rx_byte == SYNC) begin
          cpu_reset_next = 1'b1;
          done_next      = 1'b0;
          error_next     = 1'b0;
          cnt_next       = '0;
          word_idx_next  = '0;
          byte_cnt_next  = '0;
          csum_next      = '0;
          state_next     = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          cnt_next[15:8] = rx_byte;
          csum_next      = csum_acc;
          state_next     = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          cnt_next[7:0] = rx_byte;
          csum_next     = csum_acc;
          if (hdr_count > DEPTH_W) begin
            error_next = 1'b1;
            state_next = S_ERROR;
          end else if (hdr_count == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          csum_next     = csum_acc;
          word_next     = word_shifted;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          // Fourth byte: present the word on the memory port during WRITE.
          if (byte_cnt_reg == 2'd3) begin
            imem_we_next    = 1'b1;
            imem_addr_next  = word_idx_reg[ADDR_W-1:0];
            imem_wdata_next = word_shifted;
            state_next      = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_idx_next = word_idx_reg + 16'd1;
        if (word_idx_reg + 16'd1 == cnt_reg) begin
          state_next = S_CHECK;
        end else begin
          state_next = S_LOAD;
        end
      end
      S_CHECK: begin
        if (accept) begin
          csum_next = csum_acc;
          if (csum_acc == 8'h00) begin
            done_next      = 1'b1;
            cpu_reset_next = 1'b0;
            state_next     = S_DONE;
          end else begin
            error_next = 1'b1;
            state_next = S_ERROR;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
